// File: rtl/pc_sequencer_if.sv
// Sequencer bus: decoder handshake, PC feedback/update and status.
// master = surrounding datapath/decoder, slave = pc_sequencer.
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                Run;
    logic [PC_WIDTH-1:0] PC;
    logic                Instr_Valid;
    logic [2:0]          Op;
    logic [PC_WIDTH-1:0] Target;
    logic                Zero;
    logic [PC_WIDTH-1:0] Next_PC;
    logic                Fetch_Req;
    logic [1:0]          State;
    logic                Halted;
    logic                Stack_Err;

    modport master (
        output Run, PC, Instr_Valid, Op, Target, Zero,
        input  Next_PC, Fetch_Req, State, Halted, Stack_Err
    );

    modport slave (
        input  Run, PC, Instr_Valid, Op, Target, Zero,
        output Next_PC, Fetch_Req, State, Halted, Stack_Err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer producing Next_PC for the program counter register.
// Optional return-address stack enabled by defining PC_STACK_EN.
module pc_sequencer #(
    parameter int                  PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  STACK_DEPTH  = 4
) (
    input logic           Clk,
    input logic           Clear_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRZ  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [PC_WIDTH-1:0] tgt_q;
    logic                zero_q;
    logic                halted_q;
    logic                err_q;
    logic                err;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] next_pc;

`ifdef PC_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0] stack_q [0:(1<<AW)-1];
    logic [SPW-1:0]      sp_q;
    logic [SPW-1:0]      sp_m1;
    logic                push, pop;

    assign sp_m1 = sp_q - SPW'(1);
`endif

    assign pc_inc = bus.PC + PC_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        next_pc = bus.PC;
        err     = 1'b0;
`ifdef PC_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        case (state_q)
            S_IDLE:  if (bus.Run) state_d = S_FETCH;
            S_FETCH: begin
                if (!bus.Run)             state_d = S_IDLE;
                else if (bus.Instr_Valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = bus.Run ? S_FETCH : S_IDLE;
                case (op_q)
                    OP_SEQ:  next_pc = pc_inc;
                    OP_JMP:  next_pc = tgt_q;
                    OP_BRZ:  next_pc = zero_q ? tgt_q : pc_inc;
`ifdef PC_STACK_EN
                    OP_CALL: begin
                        if (sp_q == SPW'(STACK_DEPTH)) err = 1'b1;
                        else begin
                            push    = 1'b1;
                            next_pc = tgt_q;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) err = 1'b1;
                        else begin
                            pop     = 1'b1;
                            next_pc = stack_q[sp_m1[AW-1:0]];
                        end
                    end
`else
                    // Without a stack a call degenerates to a jump and return is illegal.
                    OP_CALL: next_pc = tgt_q;
                    OP_RET:  err = 1'b1;
`endif
                    OP_HALT: state_d = S_HALT;
                    default: next_pc = pc_inc;
                endcase
                if (err) state_d = S_HALT;
            end
            S_HALT:  if (!bus.Run) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clear_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SEQ;
            tgt_q    <= '0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == S_HALT);
            if (state_q == S_EXEC && err) err_q <= 1'b1;
            if (state_q == S_FETCH && bus.Run && bus.Instr_Valid) begin
                op_q   <= bus.Op;
                tgt_q  <= bus.Target;
                zero_q <= bus.Zero;
            end
        end
    end

`ifdef PC_STACK_EN
    // Pointer lives under reset so an aborted EXEC never commits a push/pop.
    always_ff @(posedge Clk) begin
        if (!Clear_n)                      sp_q <= '0;
        else if (state_q == S_EXEC && push) sp_q <= sp_q + SPW'(1);
        else if (state_q == S_EXEC && pop)  sp_q <= sp_m1;
    end

    always_ff @(posedge Clk) begin
        if (Clear_n && state_q == S_EXEC && push) stack_q[sp_q[AW-1:0]] <= pc_inc;
    end
`endif

    assign bus.Next_PC   = Clear_n ? next_pc : RESET_VECTOR;
    assign bus.Fetch_Req = (state_q == S_FETCH);
    assign bus.State     = state_q;
    assign bus.Halted    = halted_q;
    assign bus.Stack_Err = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected Next_PC per EXEC cycle goes into a
// scoreboard queue; a negedge monitor pops and compares. Status checked inline.
module tb_pc_sequencer;
    localparam logic [2:0] SEQ = 3'b000, JMP = 3'b001, BRZ = 3'b010,
                           CAL = 3'b011, RET = 3'b100, HLT = 3'b101;

    logic       Clk = 1'b0;
    logic       Clear_n;
    logic       pc_ld_en;
    logic [7:0] pc_ld_val;
    logic [7:0] exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    pc_sequencer_if #(.PC_WIDTH(8)) ifc ();

    pc_sequencer #(.PC_WIDTH(8), .RESET_VECTOR(8'h00), .STACK_DEPTH(4)) dut (
        .Clk     (Clk),
        .Clear_n (Clear_n),
        .bus     (ifc.slave)
    );

    always #5 Clk = ~Clk;

    // Program counter register fed by Next_PC, with a bench-side preload.
    always @(posedge Clk) ifc.PC <= pc_ld_en ? pc_ld_val : ifc.Next_PC;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (ifc.State == 2'b10) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected_exec: got Next_PC %0h expected no EXEC", ifc.Next_PC);
            end else begin
                chk("sb_next_pc", {24'h0, ifc.Next_PC}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_pc(input logic [7:0] v);
        pc_ld_en  = 1'b1;
        pc_ld_val = v;
        tick();
        pc_ld_en  = 1'b0;
    endtask

    task automatic do_reset();
        Clear_n = 1'b0;
        ifc.Run = 1'b0;
        ifc.Instr_Valid = 1'b0;
        tick();
        tick();
        Clear_n = 1'b1;
    endtask

    // Issue one instruction from FETCH; optionally drop Run or assert Clear_n during EXEC.
    task automatic issue(input logic [2:0] op, input logic [7:0] tgt, input logic z,
                         input logic [7:0] exp, input logic run_ex, input logic clr_ex);
        int n = 0;
        while (ifc.State != 2'b01 && n < 20) begin
            tick();
            n++;
        end
        if (ifc.State != 2'b01) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_fetch: got state %0d expected 1", ifc.State);
            return;
        end
        chk("fetch_req", {31'h0, ifc.Fetch_Req}, 32'h1);
        ifc.Instr_Valid = 1'b1;
        ifc.Op = op;
        ifc.Target = tgt;
        ifc.Zero = z;
        exp_q.push_back(exp);
        tick();
        ifc.Instr_Valid = 1'b0;
        ifc.Op = 3'b111;
        ifc.Run = run_ex;
        Clear_n = !clr_ex;
        tick();
        Clear_n = 1'b1;
        chk("pc_after", {24'h0, ifc.PC}, {24'h0, exp});
    endtask

    initial begin
        Clear_n = 1'b0;
        ifc.Run = 1'b0;
        ifc.Instr_Valid = 1'b0;
        ifc.Op = 3'b000;
        ifc.Target = 8'h00;
        ifc.Zero = 1'b0;
        pc_ld_en = 1'b1;
        pc_ld_val = 8'h55;
        tick();
        pc_ld_en = 1'b0;
        @(negedge Clk);
        chk("reset_next_pc", {24'h0, ifc.Next_PC}, 32'h00);
        do_reset();
        chk("reset_state", {30'h0, ifc.State}, 32'h0);
        chk("reset_halted", {31'h0, ifc.Halted}, 32'h0);
        chk("reset_fetch_req", {31'h0, ifc.Fetch_Req}, 32'h0);
        chk("reset_stack_err", {31'h0, ifc.Stack_Err}, 32'h0);
        chk("reset_pc", {24'h0, ifc.PC}, 32'h00);

        // Sequential stepping, branches, jumps and wrap.
        ifc.Run = 1'b1;
        set_pc(8'h10);
        issue(SEQ, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0);
        issue(SEQ, 8'h00, 1'b0, 8'h12, 1'b1, 1'b0);
        issue(SEQ, 8'h00, 1'b0, 8'h13, 1'b1, 1'b0);
        issue(SEQ, 8'h00, 1'b0, 8'h14, 1'b1, 1'b0);
        issue(BRZ, 8'h40, 1'b1, 8'h40, 1'b1, 1'b0);
        issue(BRZ, 8'h80, 1'b0, 8'h41, 1'b1, 1'b0);
        issue(JMP, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0);
        issue(SEQ, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        issue(3'b110, 8'h33, 1'b1, 8'h01, 1'b1, 1'b0);
        issue(3'b111, 8'h33, 1'b1, 8'h02, 1'b1, 1'b0);

        // Run dropped in FETCH with no instruction.
        ifc.Run = 1'b0;
        tick();
        chk("run_drop_state", {30'h0, ifc.State}, 32'h0);
        chk("run_drop_pc", {24'h0, ifc.PC}, 32'h02);
        ifc.Run = 1'b1;

        // Run dropped during EXEC still completes the instruction.
        issue(JMP, 8'h90, 1'b0, 8'h90, 1'b0, 1'b0);
        chk("exec_run_drop_state", {30'h0, ifc.State}, 32'h0);
        ifc.Run = 1'b1;

        // Halt holds with Run high, leaves to IDLE with Run low.
        issue(HLT, 8'h12, 1'b0, 8'h90, 1'b1, 1'b0);
        chk("halt_state", {30'h0, ifc.State}, 32'h3);
        chk("halt_halted", {31'h0, ifc.Halted}, 32'h1);
        chk("halt_no_err", {31'h0, ifc.Stack_Err}, 32'h0);
        tick();
        chk("halt_hold", {30'h0, ifc.State}, 32'h3);
        ifc.Run = 1'b0;
        tick();
        chk("halt_exit", {30'h0, ifc.State}, 32'h0);
        chk("halt_exit_halted", {31'h0, ifc.Halted}, 32'h0);
        ifc.Run = 1'b1;

`ifdef PC_STACK_EN
        set_pc(8'h20);
        issue(CAL, 8'h80, 1'b0, 8'h80, 1'b1, 1'b0);
        issue(RET, 8'h00, 1'b0, 8'h21, 1'b1, 1'b0);
        issue(CAL, 8'hA0, 1'b0, 8'hA0, 1'b1, 1'b0);
        issue(CAL, 8'hA1, 1'b0, 8'hA1, 1'b1, 1'b0);
        issue(CAL, 8'hA2, 1'b0, 8'hA2, 1'b1, 1'b0);
        issue(CAL, 8'hA3, 1'b0, 8'hA3, 1'b1, 1'b0);
        issue(CAL, 8'hA4, 1'b0, 8'hA3, 1'b1, 1'b0);
        chk("overflow_err", {31'h0, ifc.Stack_Err}, 32'h1);
        chk("overflow_halted", {31'h0, ifc.Halted}, 32'h1);
        chk("overflow_state", {30'h0, ifc.State}, 32'h3);
`else
        set_pc(8'h20);
        issue(CAL, 8'h80, 1'b0, 8'h80, 1'b1, 1'b0);
        chk("call_as_jump_err", {31'h0, ifc.Stack_Err}, 32'h0);
`endif
        do_reset();

        // Return with nothing to pop is a sticky error.
        ifc.Run = 1'b1;
        set_pc(8'h50);
        issue(RET, 8'h00, 1'b0, 8'h50, 1'b1, 1'b0);
        chk("ret_err", {31'h0, ifc.Stack_Err}, 32'h1);
        chk("ret_state", {30'h0, ifc.State}, 32'h3);
        ifc.Run = 1'b0;
        tick();
        chk("ret_idle", {30'h0, ifc.State}, 32'h0);
        chk("ret_err_sticky", {31'h0, ifc.Stack_Err}, 32'h1);
        ifc.Run = 1'b1;
        issue(SEQ, 8'h00, 1'b0, 8'h51, 1'b1, 1'b0);
        chk("ret_err_sticky2", {31'h0, ifc.Stack_Err}, 32'h1);
        do_reset();
        chk("err_cleared", {31'h0, ifc.Stack_Err}, 32'h0);

        // Reset during EXEC of a call aborts it; a later return finds an empty stack.
        ifc.Run = 1'b1;
        set_pc(8'h60);
        issue(CAL, 8'h70, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("clr_exec_state", {30'h0, ifc.State}, 32'h0);
        chk("clr_exec_err", {31'h0, ifc.Stack_Err}, 32'h0);
        issue(RET, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("clr_no_push", {31'h0, ifc.Stack_Err}, 32'h1);

        ifc.Run = 1'b0;
        tick();
        tick();
        chk("sb_drain", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
